// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the iterative divider.
package div_pkg;
  localparam int W  = 32;
  localparam int CW = 6;

  localparam logic [W-1:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic s);
    return (s && v[W-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
import div_pkg::*;

module div_step (
  input  logic [W:0]   rem,
  input  logic         dbit,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_nxt,
  output logic         qbit
);
  logic [W:0] shifted;
  logic [W:0] trial;

  // rem < dvs always holds, so shifted < 2*dvs and the trial sign bit is exact.
  assign shifted = {rem[W-1:0], dbit};
  assign trial   = shifted - {1'b0, dvs};
  assign qbit    = ~trial[W];
  assign rem_nxt = qbit ? trial : shifted;
endmodule

// File: rtl/div_seq.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per clock.
import div_pkg::*;

module div_seq (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          sign,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  q,
  output logic [W-1:0]  r,
  output logic          busy,
  output logic          done,
  output logic          dz
);
  state_t        state;
  logic [CW-1:0] cnt;
  logic          sgn, neg_a, neg_b, dz_path;
  logic [W-1:0]  dvd;   // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs;
  logic [W:0]    rem;
  logic [W:0]    rem_nxt;
  logic          qbit;

  div_step u_step (
    .rem     (rem),
    .dbit    (dvd[W-1]),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      sgn     <= 1'b0;
      neg_a   <= 1'b0;
      neg_b   <= 1'b0;
      dz_path <= 1'b0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dz      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sgn     <= sign;
            neg_a   <= a[W-1];
            neg_b   <= b[W-1];
            dvs     <= mag(b, sign);
            rem     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            dz_path <= (b == '0);
            // The divide-by-zero path returns the raw dividend as remainder.
            dvd     <= (b == '0) ? a : mag(a, sign);
            state   <= (b == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[W-2:0], qbit};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= FIX;
        end
        FIX: begin
          if (dz_path) begin
            q <= DZ_QUOT;
            r <= dvd;
          end else begin
            q <= (sgn && (neg_a ^ neg_b)) ? -dvd : dvd;
            r <= (sgn && neg_a) ? -rem[W-1:0] : rem[W-1:0];
          end
          dz    <= dz_path;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed vectors, independent done monitor.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q, r;
  logic        busy, done, dz;

  div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sign(sign), .a(a), .b(b),
    .q(q), .r(r), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Called at a negedge; the next posedge accepts, results appear lat cycles on.
  task automatic push(input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz;
    e.at = cyc + (edz ? 2 : 34);
    sb.push_back(e);
  endtask

  task automatic issue(input logic s, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    @(negedge clk);
    sign = s; a = aa; b = bb; start = 1'b1;
    push(eq, er, edz);
    @(negedge clk);
    start = 1'b0;
    sign = ~s; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (!busy && sb.size() == 0) return;
    end
    ntests++; nfail++;
    $display("FAIL %s: timeout waiting for result, pending=%0d", name, sb.size());
    sb.delete();
  endtask

  // Monitor: every done pulse must match the oldest expectation, at the expected cycle.
  logic done_q = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (done) begin
      if (done_q) begin
        ntests++; nfail++;
        $display("FAIL done_width: done high for two cycles at cyc %0d", cyc);
      end
      chk("busy_at_done", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected_done: q=%h r=%h dz=%b with nothing pending", q, r, dz);
      end else begin
        e_mon = sb.pop_front();
        chk("q", q, e_mon.q);
        chk("r", r, e_mon.r);
        chk("dz", {31'b0, dz}, {31'b0, e_mon.dz});
        chk("latency", cyc, e_mon.at);
      end
    end
    done_q = done;
  end

  initial begin
    #12;
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, dz}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    repeat (5) @(negedge clk);
    chk("busy_mid", {31'b0, busy}, 32'd1);
    wait_idle("u100_7");

    issue(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0); wait_idle("s-7_2");
    issue(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0);         wait_idle("s7_-2");
    issue(1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0); wait_idle("s-100_7");
    issue(1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 0); wait_idle("s-7_-2");
    issue(0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);                 wait_idle("dz_u");
    issue(1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);                 wait_idle("dz_s");
    issue(1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1); wait_idle("dz_neg");
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);                      wait_idle("dz_clear");
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0); wait_idle("ovf");
    issue(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);         wait_idle("umax_1");
    issue(0, 32'd3, 32'd10, 32'd0, 32'd3, 0);                        wait_idle("small");
    issue(0, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, 32'd2, 0); wait_idle("u_big");

    // A start while busy must be dropped without disturbing the operation.
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    repeat (9) @(negedge clk);
    sign = 1'b1; a = 32'd50; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored", {31'b0, busy}, 32'd1);
    wait_idle("ignored_start");

    // start held high: the second divide is taken in the done cycle.
    @(negedge clk);
    sign = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    push(32'd14, 32'd2, 1'b0);
    begin
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (done) begin seen = 1; break; end
      end
      if (seen) begin
        a = 32'd1000; b = 32'd10;
        push(32'd100, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_b2b", {31'b0, busy}, 32'd1);
      end else begin
        start = 1'b0;
        ntests++; nfail++;
        $display("FAIL held_start: no done within bound");
      end
    end
    wait_idle("held_start");

    // Asynchronous reset mid-operation clears everything at once.
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_q", q, 32'd0);
    chk("mid_rst_r", r, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    wait_idle("after_rst");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative 32-bit integer divider for the CPU datapath; the multi-cycle counterpart to the single-cycle add/sub unit.
- Computes quotient and remainder, signed or unsigned, with one restoring-division step (trial subtract) per clock.
- Sits beside the ALU; the control unit starts it with a one-cycle pulse and stalls until done.

Parameters:
- W, 32, operand/result width (only 32 is verified).
- CW, 6, iteration counter width (must hold W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only while idle
- sign  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
- a  in  32  dividend; sampled with start
- b  in  32  divisor; sampled with start
- q  out  32  quotient; registered, held until next accepted start
- r  out  32  remainder; registered, held until next accepted start
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse: q/r/dz valid
- dz  out  1  divide-by-zero flag; valid with done, held with q/r

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-operation): state IDLE; q=0, r=0, busy=0, done=0, dz=0; internal registers and counter cleared. No partial result survives.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1 at edge k, capture sign, the sign of a, the sign of b, |a| and |b|. Magnitudes are two's-complement absolute values when sign=1, raw operands otherwise.
  - Clear the partial remainder (33 bits) and the counter.
  - Go to CALC, or directly to FIX with the dz path if b==0.
  - Set busy=1 from edge k.
  - start=0 leaves all outputs unchanged.
- CALC, edges k+1 .. k+32, one step per edge, MSB first:
  - Shift {rem, dividend} left 1.
  - Trial value = rem - |b|, 33-bit. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter increments; after the 32nd step, go to FIX.
- FIX, edge k+33 (normal path) or edge k+1 (dz path):
  - Normal path:
    - q = magnitude quotient, negated if sign=1 and operand signs differ.
    - r = magnitude remainder, negated if sign=1 and dividend negative (remainder takes the dividend's sign).
    - dz = 0.
  - dz path: q = 32'hFFFFFFFF, r = a (unmodified), dz = 1, regardless of sign.
  - Overflow case (signed 0x80000000 / 0xFFFFFFFF): q = 0x80000000, r = 0, no flag. This falls out of the magnitude algorithm.
  - done=1 and busy=0 after this edge; state returns to IDLE.
- Latency: done is high in the cycle after edge k+33 (dz: after edge k+1). A new start is accepted in that same done cycle; done then deasserts on the next edge and busy reasserts.
- start while busy=1: ignored. The operation in flight is not disturbed and no request is queued.
- a, b and sign may change freely after the accepting edge.
- done is never high for more than one cycle. q, r and dz do not change except at a FIX edge or on reset.

Decomposition:
- Shared package div_pkg:
  - W and CW constants.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - DZ_QUOT = 32'hFFFFFFFF.
- One sub-module, div_step (combinational):
  - Inputs: 33-bit remainder, next dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Instantiated once; div_seq holds all registers and the FSM.

Test Plan:
- Unsigned: sign=0, a=100, b=7, start at edge k -> busy 1 during edges k..k+33, done pulse after edge k+33, q=14, r=2, dz=0.
- Signed mixed signs: sign=1, a=-7 (0xFFFFFFF9), b=2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also a=7, b=-2 -> q=-3, r=1.
- Divide by zero: a=5, b=0, sign either value -> done after edge k+1, q=0xFFFFFFFF, r=5, dz=1. Next valid divide clears dz.
- Boundaries:
  - sign=1, a=0x80000000, b=0xFFFFFFFF -> q=0x80000000, r=0.
  - sign=0, a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0.
  - sign=0, a=3, b=10 -> q=0, r=3.
- Handshake:
  - start pulsed at iteration 10 with different operands -> ignored, first result correct.
  - start held high through done -> second division accepted in the done cycle, done is exactly one cycle wide.
- Reset mid-operation: rst_n low at iteration 10 -> q=0, r=0, busy=0, done=0 immediately (asynchronous). After release, 100/7 gives q=14, r=2 with normal latency.
